// File: rtl/keypad_matrix_emulator.sv
// Emulated 4x4 keypad: plays a requested key press as press bounce, hold, release
// bounce and gap, driving active-low rows in response to the scanner's column strobes.
module keypad_matrix_emulator #(
    parameter int HOLD_CYCLES   = 1000,
    parameter int BOUNCE_CYCLES = 16,
    parameter int BOUNCE_PERIOD = 2,
    parameter int GAP_CYCLES    = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    input  logic       req_valid,
    input  logic [3:0] req_key,
    output logic       req_ready,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [7:0] press_count
);
    localparam int MAX_HG     = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_CYCLES = (MAX_HG > BOUNCE_CYCLES) ? MAX_HG : BOUNCE_CYCLES;
    // +1 so that a power-of-two phase length still fits as a load value.
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam int TW = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;

    localparam logic [CW-1:0] L_HOLD     = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] L_BOUNCE   = CW'(BOUNCE_CYCLES);
    localparam logic [CW-1:0] L_GAP      = CW'(GAP_CYCLES);
    localparam logic [TW-1:0] L_TOG_LAST = TW'(BOUNCE_PERIOD - 1);
    localparam bit            NO_BOUNCE  = (BOUNCE_CYCLES == 0);

    typedef enum logic [2:0] {S_IDLE, S_PB, S_HOLD, S_RB, S_GAP} state_t;

    state_t        r_state;
    logic          r_contact;
    logic [3:0]    r_key;
    logic [CW-1:0] r_cnt;
    logic [TW-1:0] r_tog;
    logic          r_done;
    logic [7:0]    r_press_count;

    logic          w_phase_end;
    logic          w_tog_now;
    logic [3:0]    w_row;

    assign w_phase_end = (r_cnt == CW'(1));
    assign w_tog_now   = (r_tog == L_TOG_LAST);

    // NOTE: every state register updates with <= so all of them see the pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_contact     <= 1'b0;
            r_key         <= '0;
            r_cnt         <= '0;
            r_tog         <= '0;
            r_done        <= 1'b0;
            r_press_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_key     <= req_key;
                        r_contact <= 1'b1;
                        r_tog     <= '0;
                        if (NO_BOUNCE) begin
                            r_state <= S_HOLD;
                            r_cnt   <= L_HOLD;
                        end else begin
                            r_state <= S_PB;
                            r_cnt   <= L_BOUNCE;
                        end
                    end
                end
                S_PB, S_RB: begin
                    if (abort || (w_phase_end && r_state == S_RB)) begin
                        r_state   <= S_GAP;
                        r_contact <= 1'b0;
                        r_cnt     <= L_GAP;
                    end else if (w_phase_end) begin
                        r_state   <= S_HOLD;
                        r_contact <= 1'b1;
                        r_cnt     <= L_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        if (w_tog_now) begin
                            r_contact <= ~r_contact;
                            r_tog     <= '0;
                        end else begin
                            r_tog <= r_tog + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (abort || (w_phase_end && NO_BOUNCE)) begin
                        r_state   <= S_GAP;
                        r_contact <= 1'b0;
                        r_cnt     <= L_GAP;
                    end else if (w_phase_end) begin
                        // Release bounce opens first, mirroring press bounce.
                        r_state   <= S_RB;
                        r_contact <= 1'b0;
                        r_cnt     <= L_BOUNCE;
                        r_tog     <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_phase_end) begin
                        r_state       <= S_IDLE;
                        r_done        <= 1'b1;
                        r_press_count <= r_press_count + 8'd1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the default assignment before the loop keeps this block latch-free.
    always_comb begin
        w_row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (r_contact && (r_key[3:2] == 2'(r)) && !col[r_key[1:0]]) begin
                w_row[r] = 1'b0;
            end
        end
    end

    assign row         = w_row;
    assign req_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign press_count = r_press_count;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Scoreboard bench for keypad_matrix_emulator: three parameter sets, expected contact
// sequences queued on request and compared cycle by cycle across all column strobes.
module tb_keypad_matrix_emulator;
    localparam int NI = 3;
    // Instance 0: clean press, 1: bouncing contact, 2: minimal timing for wrap.
    localparam int H0 = 10, B0 = 0, P0 = 2, G0 = 5;
    localparam int H1 = 10, B1 = 8, P1 = 2, G1 = 5;
    localparam int H2 = 1,  B2 = 0, P2 = 2, G2 = 1;

    typedef struct {
        logic       contact;
        logic [3:0] key;
    } exp_cyc_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    col;
    logic [3:0]    req_key;
    logic [NI-1:0] valid_v;
    logic [NI-1:0] abort_v;
    logic [NI-1:0] ready_v;
    logic [NI-1:0] busy_v;
    logic [NI-1:0] done_v;
    logic [3:0]    row [NI];
    logic [7:0]    pc  [NI];

    exp_cyc_t   cyc_q [$];
    logic [7:0] pc_q  [$];
    logic [7:0] exp_pc [NI];
    logic [3:0] col_pat [6];
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    keypad_matrix_emulator #(.HOLD_CYCLES(H0), .BOUNCE_CYCLES(B0), .BOUNCE_PERIOD(P0), .GAP_CYCLES(G0)) u_dut_clean (
        .clk(clk), .rst(rst), .col(col), .row(row[0]), .req_valid(valid_v[0]), .req_key(req_key),
        .req_ready(ready_v[0]), .abort(abort_v[0]), .busy(busy_v[0]), .done(done_v[0]), .press_count(pc[0]));
    keypad_matrix_emulator #(.HOLD_CYCLES(H1), .BOUNCE_CYCLES(B1), .BOUNCE_PERIOD(P1), .GAP_CYCLES(G1)) u_dut_bounce (
        .clk(clk), .rst(rst), .col(col), .row(row[1]), .req_valid(valid_v[1]), .req_key(req_key),
        .req_ready(ready_v[1]), .abort(abort_v[1]), .busy(busy_v[1]), .done(done_v[1]), .press_count(pc[1]));
    keypad_matrix_emulator #(.HOLD_CYCLES(H2), .BOUNCE_CYCLES(B2), .BOUNCE_PERIOD(P2), .GAP_CYCLES(G2)) u_dut_fast (
        .clk(clk), .rst(rst), .col(col), .row(row[2]), .req_valid(valid_v[2]), .req_key(req_key),
        .req_ready(ready_v[2]), .abort(abort_v[2]), .busy(busy_v[2]), .done(done_v[2]), .press_count(pc[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int cfg(input int s, input int which);
        int v [4];
        case (s)
            0:       v = '{H0, B0, P0, G0};
            1:       v = '{H1, B1, P1, G1};
            default: v = '{H2, B2, P2, G2};
        endcase
        return v[which];
    endfunction

    // A closed contact pulls exactly the key's row low while the key's column is strobed.
    function automatic logic [3:0] exp_row(input logic contact, input logic [3:0] key, input logic [3:0] c);
        logic [3:0] onehot;
        onehot = 4'b0001 << key[3:2];
        if (contact && (c[key[1:0]] == 1'b0)) return ~onehot;
        return 4'b1111;
    endfunction

    task automatic scan_rows(input int s, input logic contact, input logic [3:0] key, input string tag);
        for (int i = 0; i < 6; i++) begin
            col = col_pat[i];
            #1;
            check(tag, row[s], exp_row(contact, key, col_pat[i]));
        end
    endtask

    // Queue the contact state for every busy cycle of one press, plus its press_count.
    task automatic push_press(input int s, input logic [3:0] key, input int abort_at);
        exp_cyc_t seq [$];
        exp_cyc_t e;
        int h = cfg(s, 0), b = cfg(s, 1), p = cfg(s, 2), g = cfg(s, 3);
        e.key = key;
        for (int i = 0; i < b; i++) begin e.contact = ((i / p) % 2 == 0); seq.push_back(e); end
        for (int i = 0; i < h; i++) begin e.contact = 1'b1; seq.push_back(e); end
        for (int i = 0; i < b; i++) begin e.contact = ((i / p) % 2 == 1); seq.push_back(e); end
        if (abort_at > 0) while (seq.size() > abort_at) void'(seq.pop_back());
        for (int i = 0; i < g; i++) begin e.contact = 1'b0; seq.push_back(e); end
        foreach (seq[i]) cyc_q.push_back(seq[i]);
        exp_pc[s] = exp_pc[s] + 8'd1;
        pc_q.push_back(exp_pc[s]);
    endtask

    task automatic accept(input int s, input logic [3:0] key, input int abort_at,
                          input logic abort_too, input logic keep_valid);
        int waited = 0;
        while (ready_v[s] !== 1'b1 && waited < 50) begin tick(); waited++; end
        check("ready_before_req", ready_v[s], 1'b1);
        req_key    = key;
        valid_v[s] = 1'b1;
        abort_v[s] = abort_too;
        push_press(s, key, abort_at);
        tick();
        abort_v[s] = 1'b0;
        if (!keep_valid) begin
            valid_v[s] = 1'b0;
            req_key    = ~key;
        end
    endtask

    // Starts in the first busy cycle, returns in the cycle where done should be high.
    task automatic run_press(input int s, input int abort_at, input string tag);
        exp_cyc_t   e;
        logic [7:0] epc;
        int         n = 0;
        while (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            n++;
            scan_rows(s, e.contact, e.key, {tag, "_row"});
            check({tag, "_busy"}, busy_v[s], 1'b1);
            check({tag, "_done_early"}, done_v[s], 1'b0);
            if (n == abort_at) abort_v[s] = 1'b1;
            tick();
            abort_v[s] = 1'b0;
        end
        epc = pc_q.pop_front();
        check({tag, "_done"}, done_v[s], 1'b1);
        check({tag, "_ready"}, ready_v[s], 1'b1);
        check({tag, "_count"}, pc[s], epc);
        scan_rows(s, 1'b0, 4'h0, {tag, "_idle_row"});
    endtask

    task automatic finish_press(input int s, input string tag);
        tick();
        check({tag, "_done_pulse"}, done_v[s], 1'b0);
    endtask

    initial begin
        col_pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b0000, 4'b1111};
        rst     = 1'b0;
        col     = 4'b1111;
        req_key = 4'h6;
        valid_v = '1;
        abort_v = '0;
        for (int s = 0; s < NI; s++) exp_pc[s] = 8'd0;

        repeat (3) tick();
        for (int s = 0; s < NI; s++) begin
            scan_rows(s, 1'b0, 4'h0, "rst_row");
            check("rst_ready", ready_v[s], 1'b1);
            check("rst_busy", busy_v[s], 1'b0);
            check("rst_done", done_v[s], 1'b0);
            check("rst_count", pc[s], 8'd0);
        end
        valid_v = '0;
        rst     = 1'b1;
        tick();
        for (int s = 0; s < NI; s++) check("rst_no_accept", busy_v[s], 1'b0);

        accept(0, 4'b0110, 0, 1'b0, 1'b0);
        run_press(0, 0, "clean");
        finish_press(0, "clean");

        accept(1, 4'b0000, 0, 1'b0, 1'b0);
        run_press(1, 0, "bounce");
        finish_press(1, "bounce");

        accept(0, 4'hA, 3, 1'b0, 1'b0);
        run_press(0, 3, "abort_hold");
        finish_press(0, "abort_hold");
        accept(1, 4'h5, B1 + 3, 1'b0, 1'b0);
        run_press(1, B1 + 3, "abort_hold_b");
        finish_press(1, "abort_hold_b");
        accept(1, 4'hC, 3, 1'b0, 1'b0);
        run_press(1, 3, "abort_pb");
        finish_press(1, "abort_pb");
        accept(0, 4'h3, 0, 1'b1, 1'b0);
        run_press(0, 0, "abort_idle");
        finish_press(0, "abort_idle");

        accept(0, 4'hF, 0, 1'b0, 1'b1);
        req_key = 4'h1;
        run_press(0, 0, "b2b_first");
        push_press(0, 4'h1, 0);
        tick();
        valid_v[0] = 1'b0;
        req_key    = 4'h0;
        run_press(0, 0, "b2b_second");
        finish_press(0, "b2b_second");

        for (int i = 0; i < 256; i++) begin
            accept(2, 4'(i), 0, 1'b0, 1'b0);
            run_press(2, 0, "wrap");
            finish_press(2, "wrap");
        end
        check("wrap_zero", pc[2], 8'd0);

        accept(0, 4'b1001, 0, 1'b0, 1'b0);
        cyc_q.delete();
        pc_q.delete();
        tick();
        tick();
        scan_rows(0, 1'b1, 4'b1001, "pre_rst_row");
        rst = 1'b0;
        tick();
        scan_rows(0, 1'b0, 4'h0, "mid_rst_row");
        check("mid_rst_ready", ready_v[0], 1'b1);
        check("mid_rst_busy", busy_v[0], 1'b0);
        check("mid_rst_count", pc[0], 8'd0);
        rst = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
